// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for the single-port unified memory.
// Port 0 is the CPU (fetch, lw/sw), port 1 is the loader/debug port. One access runs
// at a time: IDLE grants, BUSY strobes the memory once and waits LATENCY cycles, ACK
// pulses the owner's ack for one cycle.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req/we/addr/wdata/ack0  CPU requester
//   req/we/addr/wdata/ack1  loader/debug requester
//   rdata                   read data, valid during the owner's ack of a read
//   mem_en/we/addr/wdata    memory strobes and latched address/data
//   mem_rdata               memory read data, valid LATENCY cycles after mem_en
//   busy, owner             transaction in progress, port of current/last transaction
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 1
// wins every tie.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [3:0] LAT = 4'(LATENCY);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we_q;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_owner;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          w_win;
    logic          w_we;
    // On a tie round-robin hands the grant to the port that was not served last.
    assign w_win = (req0 && req1) ? (RR ? !r_owner : 1'b1) : req1;
    assign w_we  = w_win ? we1 : we0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we_q      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_owner     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state     <= BUSY;
                        r_owner     <= w_win;
                        r_cnt       <= '0;
                        r_we_q      <= w_we;
                        r_mem_addr  <= w_win ? addr1 : addr0;
                        r_mem_wdata <= w_win ? wdata1 : wdata0;
                        // Strobes are registered so they are high exactly while cnt==0.
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_we;
                    end
                end
                BUSY: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == LAT) begin
                        if (!r_we_q) r_rdata <= mem_rdata;
                        r_state <= ACK;
                        r_ack0  <= !r_owner;
                        r_ack1  <= r_owner;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                end
            endcase
        end
    end
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign owner     = r_owner;
    assign busy      = r_state != IDLE;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port unified instruction/data memory of the multicycle core between two requesters.
- Port 0 is the CPU: instruction fetch plus lw/sw, addressed by the iord mux.
- Port 1 is the loader/debug port, used for program load and memory inspection.
- Performs one access at a time with a fixed, parameterised memory latency, and returns a one-cycle ack per transaction so the CPU FSM can hold its state until the access completes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 0..15; 0 means combinational read.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  CPU request.
- we0  in  1  CPU write enable.
- addr0  in  AW  CPU address.
- wdata0  in  DW  CPU write data.
- ack0  out  1  CPU transaction complete, one-cycle pulse.
- req1  in  1  loader request.
- we1  in  1  loader write enable.
- addr1  in  AW  loader address.
- wdata1  in  DW  loader write data.
- ack1  out  1  loader transaction complete, one-cycle pulse.
- rdata  out  DW  read data; valid during ack0/ack1 of a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  a transaction is in progress (state != IDLE).
- owner  out  1  requester of the current or last transaction.

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is asynchronous and active-high. On reset: state=IDLE, cnt=0, and ack0, ack1, mem_en, mem_we, busy and owner are 0. rdata, mem_addr and mem_wdata are 0.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until it samples its ack high.
  - It drops req on that same edge.
  - A req still high in the IDLE cycle after ack is a new transaction.
- FSM has 3 states: IDLE, BUSY, ACK.
- IDLE:
  - If req0 or req1 is high, select a winner; ties go to port 1, which has fixed priority.
  - Latch the winner's addr, we and wdata into mem_addr, mem_wdata and an internal we_q; set owner; clear cnt; go to BUSY.
  - If neither req is high, stay in IDLE.
- BUSY:
  - mem_en=1 and mem_we=we_q only while cnt==0, so there is exactly one strobe per transaction.
  - cnt increments each cycle.
  - When cnt==LATENCY: if we_q==0, capture mem_rdata into rdata; go to ACK.
  - For writes, rdata is left unchanged.
- ACK: assert ack[owner] for exactly one cycle, then go to IDLE.
- Latency: with req sampled in IDLE at edge t, mem_en is high in cycle t+1 and ack is high in cycle t+2+LATENCY. With LATENCY=1, ack comes 3 cycles after req is sampled.
- Throughput: one transaction per LATENCY+3 cycles.
- mem_addr and mem_wdata hold their latched values until the next grant; they do not return to 0.
- A loser's req stays pending and is served in the IDLE cycle following the winner's ACK.
- Requests arriving while the block is busy are ignored until IDLE; they are not queued.
- A req deasserted before grant is dropped silently. This is illegal per the handshake but must not hang the block.
- ack0 and ack1 are never high simultaneously. mem_en is never high outside BUSY with cnt==0.
- Reset mid-transaction:
  - Immediate return to IDLE with all strobes low and no ack.
  - If reset asserts before the mem_en edge, no write reaches memory.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the port not equal to owner wins. A single requester always wins. After reset, owner=0, so port 1 wins the first tie.
- Undefined: fixed priority, port 1 over port 0, as described above.

Test Plan:
- Single CPU read, LATENCY=1:
  - Stimulus: req0=1, we0=0, addr0=0x10; memory holds 0xDEADBEEF at 0x10.
  - Required: mem_en pulses once with mem_addr=0x10; ack0 pulses in cycle t+3 with rdata=0xDEADBEEF; ack1 stays 0.
- Loader write then CPU read-back:
  - Stimulus: req1 write of 0x12345678 to 0x20, then req0 read of 0x20.
  - Required: exactly one mem_we pulse; ack1, then ack0 with rdata=0x12345678; rdata unchanged across ack1.
- Simultaneous requests, fixed priority:
  - Stimulus: req0 and req1 rise together on reads of 0x4 and 0x8.
  - Required: port 1 served first (mem_addr=0x8), port 0 next (mem_addr=0x4); acks are 4 cycles apart.
- Same stimulus with MEM_ARB_RR_EN defined, both ports requesting continuously for 4 transactions:
  - Required: grant order is 1, 0, 1, 0.
- Reset asserted the cycle after grant of a write to 0x30:
  - Required: mem_we never high, no ack, busy=0 immediately; memory at 0x30 unchanged.
- LATENCY=0 and LATENCY=4 builds, each with a single read:
  - Required: ack at t+2 and t+6 respectively, with correct rdata.
